onehot_to_bin: RTL and testbench
================================

// Module: onehot_to_bin
// PURPOSE
//  Registered one-hot to binary encoder with legality checking. Converts a
//  STATE_W-bit one-hot vector (e.g. an FSM state or arbiter grant) into its
//  bit index. Flags whether the input was a legal one-hot code, and flags
//  multi-hot corruption separately. Sits between one-hot control logic and
//  binary-indexed consumers (muxes, RAM addresses, status registers).
// PARAMETERS
//  STATE_W  8                  width of one-hot input; >= 2
//  BIN_W    $clog2(STATE_W)    width of binary output (package-derived)
// PORTS
//  clk_i     in   1        clock, all state updates on rising edge
//  rst_i     in   1        asynchronous, active-high reset
//  onehot_i  in   STATE_W  one-hot code to encode; sampled every cycle
//  bin_o     out  BIN_W    index of the set bit (registered)
//  valid_o   out  1        1 = previous-cycle input had exactly one bit set
//  err_o     out  1        1 = previous-cycle input had two or more bits set
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset: bin_o=0, valid_o=0, err_o=0, held while rst_i=1. First capture is
//    on the first rising edge after rst_i deasserts.
//  - Latency: exactly 1 cycle. Input sampled on edge N appears on outputs after
//    edge N. No handshake; a new input is accepted every cycle.
//  - Legal code: exactly one bit k of onehot_i is set.
//    Registers bin_o=k (unsigned, LSB = bit 0), valid_o=1, err_o=0.
//  - All-zero input: bin_o=0, valid_o=0, err_o=0.
//  - Multi-hot input (popcount >= 2): bin_o=0, valid_o=0, err_o=1.
//    No partial or priority index is reported.
//  - valid_o and err_o are never 1 together.
//  - Legality check: (x != 0) && ((x & (x-1)) == 0). Multi-hot = (x & (x-1)) != 0.
//  - Encoding: bin bit j = OR of onehot_i[i] for every i with bit j of i set.
//    The result is gated to 0 when the input is not legal.
//  - Bits of index space beyond STATE_W-1 (non-power-of-2 widths) are never
//    produced.
//  - Reset asserted mid-stream clears all outputs immediately, without waiting
//    for a clock edge. The pipeline holds no other state.
//  - No X propagation: outputs are always driven from registers.
// TESTING
//  1. rst_i=1 with any onehot_i -> bin_o=0, valid_o=0, err_o=0, asynchronously.
//  2. onehot_i=8'b0010_0000 -> after next edge: bin_o=3'd5, valid_o=1, err_o=0.
//  3. onehot_i=8'b1000_0000, then 8'b0000_0001 on consecutive edges
//     -> bin_o=7 then 0, valid_o=1 both cycles.
//  4. onehot_i=8'b1111_1111 -> bin_o=0, valid_o=0, err_o=1.
//     Repeat with 8'b0000_0011 -> same result.
//  5. onehot_i=8'h00 -> bin_o=0, valid_o=0, err_o=0.
//  6. Walk the set bit 0..7, then assert rst_i between edges
//     -> bin_o tracks 0..7 with 1-cycle lag; outputs drop to 0 at once on rst_i.

Source files
------------

// File: rtl/onehot_to_bin_if.sv
// Purpose: groups the one-hot encoder's data signals into one bundle.
//   master modport (producer/consumer side): drives onehot_i, observes outputs.
//   slave  modport (encoder side)          : reads onehot_i, drives outputs.
// Signals:
//   onehot_i  STATE_W  one-hot code to encode
//   bin_o     BIN_W    registered index of the set bit
//   valid_o   1        previous input held exactly one set bit
//   err_o     1        previous input held two or more set bits
interface onehot_to_bin_if #(
    parameter int STATE_W = 8,
    parameter int BIN_W   = $clog2(STATE_W)
);
    logic [STATE_W-1:0] onehot_i;
    logic [BIN_W-1:0]   bin_o;
    logic               valid_o;
    logic               err_o;

    modport master (
        output onehot_i,
        input  bin_o,
        input  valid_o,
        input  err_o
    );

    modport slave (
        input  onehot_i,
        output bin_o,
        output valid_o,
        output err_o
    );
endinterface

// File: rtl/onehot_to_bin.sv
// Purpose: registered one-hot to binary encoder with legality checking.
//   A legal code (exactly one bit k set) yields bin_o=k, valid_o=1.
//   All-zero yields all outputs 0; multi-hot yields err_o=1 and bin_o=0.
//   Latency is one clock; a new input is accepted every cycle.
// Ports:
//   clk_i  in  clock, rising edge
//   rst_i  in  asynchronous active-high reset, clears all outputs
//   bus    slave modport of onehot_to_bin_if (onehot_i, bin_o, valid_o, err_o)
module onehot_to_bin #(
    parameter int STATE_W = 8,
    parameter int BIN_W   = $clog2(STATE_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    onehot_to_bin_if.slave     bus
);

    logic [STATE_W-1:0] x;
    logic [STATE_W-1:0] x_minus_1;
    logic               multi;
    logic               legal;
    logic [BIN_W-1:0]   enc;

    logic [BIN_W-1:0]   bin_d,   bin_q;
    logic               valid_d, valid_q;
    logic               err_d,   err_q;

    assign x = bus.onehot_i;

    always_comb begin
        x_minus_1 = x - {{(STATE_W-1){1'b0}}, 1'b1};
        // x & (x-1) clears the lowest set bit; anything left means >= 2 bits set.
        multi     = (x & x_minus_1) != '0;
        legal     = (x != '0) && !multi;

        // Bit j of the index is the OR of every input bit whose position has bit j set.
        // Only positions 0..STATE_W-1 contribute, so indices beyond the width never appear.
        enc = '0;
        for (int unsigned i = 0; i < STATE_W; i++) begin
            for (int unsigned j = 0; j < BIN_W; j++) begin
                if (((i >> j) & 32'd1) != 32'd0) begin
                    enc[j] = enc[j] | x[i];
                end
            end
        end

        bin_d   = legal ? enc : '0;
        valid_d = legal;
        err_d   = multi;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.bin_o   = bin_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_onehot_to_bin.sv
// Purpose: directed self-checking bench for onehot_to_bin (STATE_W = 8).
module tb_onehot_to_bin;

    localparam int STATE_W = 8;
    localparam int BIN_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    onehot_to_bin_if #(.STATE_W(STATE_W), .BIN_W(BIN_W)) bus ();

    onehot_to_bin #(.STATE_W(STATE_W), .BIN_W(BIN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] b, input logic v, input logic e);
        check({tag, ".bin"},   32'(bus.bin_o),   32'(b));
        check({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
        check({tag, ".err"},   32'(bus.err_o),   32'(e));
    endtask

    // Drive on the falling edge, sample 1 ns after the capturing rising edge.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        bus.onehot_i = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.onehot_i = 8'hFF;
        #1;
        rst = 1'b1;
        #2;
        check_out("rst_async", 3'd0, 1'b0, 1'b0);

        // Held in reset across an edge even with a legal code present.
        bus.onehot_i = 8'h10;
        @(posedge clk);
        #1;
        check_out("rst_hold", 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        apply(8'b0010_0000);
        check_out("bit5", 3'd5, 1'b1, 1'b0);

        apply(8'b1000_0000);
        check_out("bit7", 3'd7, 1'b1, 1'b0);
        apply(8'b0000_0001);
        check_out("bit0", 3'd0, 1'b1, 1'b0);

        apply(8'b1111_1111);
        check_out("allones", 3'd0, 1'b0, 1'b1);
        apply(8'b0000_0011);
        check_out("two_low", 3'd0, 1'b0, 1'b1);
        apply(8'b1000_0100);
        check_out("two_far", 3'd0, 1'b0, 1'b1);

        apply(8'h00);
        check_out("zero", 3'd0, 1'b0, 1'b0);

        // Legal code right after multi-hot: err must clear.
        apply(8'b0000_1000);
        check_out("bit3_after_err", 3'd3, 1'b1, 1'b0);

        // Output only changes at the edge: mid-cycle input change is not visible.
        @(negedge clk);
        bus.onehot_i = 8'b0100_0000;
        #2;
        check_out("latency_hold", 3'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("bit6", 3'd6, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] v;
            v = 8'd1 << k;
            apply(v);
            check_out($sformatf("walk%0d", k), 3'(k), 1'b1, 1'b0);
        end

        // Reset between edges: outputs drop before any further clock.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_mid", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.onehot_i = 8'b0000_0100;
        @(posedge clk);
        #1;
        check_out("first_after_rst", 3'd2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
